// File: rtl/clkgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clkgen_pkg
//  Description : Shared types and reset-time constants for the programmable
//                clock generator (state encoding, default active config).
//  Revision    : 1.0 - initial release
// ============================================================================
package clkgen_pkg;

  // Generator phases; div_out is high only in ST_HIGH.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFSET = 2'd1,
    ST_HIGH   = 2'd2,
    ST_LOW    = 2'd3
  } clkgen_state_t;

  // Active configuration loaded on reset.
  localparam int c_rst_period = 2;
  localparam int c_rst_high   = 1;
  localparam int c_rst_offset = 0;

  // Shortest legal period; smaller requests are raised to this.
  localparam int c_min_period = 2;

endpackage
`default_nettype wire

// File: rtl/clkgen_phase_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : clkgen_phase_cnt
//  Description : Loadable down-counter with terminal-count flag. Loading N-1
//                makes tc rise after N cycles in the current phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module clkgen_phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] r_cnt;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/clkgen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clkgen_ctrl
//  Description : Programmable divided-clock generator with start offset,
//                shadowed configuration applied only at period boundaries,
//                and glitch-free stop at the end of the current period.
//                Optional macro CLKGEN_CTRL_CNT_EN adds the 32-bit
//                period_cnt output (completed periods since start).
//  Revision    : 1.0 - initial release
// ============================================================================
module clkgen_ctrl
  import clkgen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_offset,
  output logic             div_out,
  output logic             rise_pulse,
  output logic             busy
`ifdef CLKGEN_CTRL_CNT_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_min_per = CNT_W'(c_min_period);

  clkgen_state_t    r_state, w_state_nxt;

  logic [CNT_W-1:0] r_act_period, r_act_high, r_act_offset;
  logic [CNT_W-1:0] r_shd_period, r_shd_high, r_shd_offset;
  logic             r_shd_full;

  logic             w_tc, w_load;
  logic [CNT_W-1:0] w_load_val;

  logic             w_skip_low, w_boundary, w_apply;
  logic [CNT_W-1:0] w_shd_period_c;
  logic [CNT_W-1:0] w_cfg_period, w_cfg_high, w_cfg_offset;
  logic [CNT_W-1:0] w_start_hi;
  clkgen_state_t    w_start_state;
  logic [CNT_W-1:0] w_start_val;

  logic             r_div, r_rise, r_busy;
  logic             w_div_nxt, w_rise_nxt, w_busy_nxt;

  // --------------------------------------------------------------------------
  // Config selection. A pending shadow is applied in IDLE or on the last
  // cycle of a period; the period starting on that edge already uses it.
  // --------------------------------------------------------------------------
  assign w_shd_period_c = (r_shd_period < c_min_per) ? c_min_per : r_shd_period;
  assign w_skip_low     = (r_act_high >= r_act_period);
  assign w_boundary     = w_tc && ((r_state == ST_LOW) ||
                                   ((r_state == ST_HIGH) && w_skip_low));
  assign w_apply        = r_shd_full && ((r_state == ST_IDLE) || w_boundary);

  assign w_cfg_period   = w_apply ? w_shd_period_c : r_act_period;
  assign w_cfg_high     = w_apply ? r_shd_high     : r_act_high;
  assign w_cfg_offset   = w_apply ? r_shd_offset   : r_act_offset;

  // High phase is capped at the period, which removes the LOW phase.
  assign w_start_hi     = (w_cfg_high >= w_cfg_period) ? w_cfg_period : w_cfg_high;
  // A zero high time starts every period directly in LOW.
  assign w_start_state  = (w_cfg_high == '0) ? ST_LOW : ST_HIGH;
  assign w_start_val    = (w_cfg_high == '0) ? (w_cfg_period - c_one)
                                             : (w_start_hi - c_one);

  assign cfg_ready      = ~r_shd_full;

  // Shadow capture and shadow-to-active transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_period <= CNT_W'(c_rst_period);
      r_act_high   <= CNT_W'(c_rst_high);
      r_act_offset <= CNT_W'(c_rst_offset);
      r_shd_period <= '0;
      r_shd_high   <= '0;
      r_shd_offset <= '0;
      r_shd_full   <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_period <= w_shd_period_c;
        r_act_high   <= r_shd_high;
        r_act_offset <= r_shd_offset;
        r_shd_full   <= 1'b0;
      end
      if (cfg_valid && !r_shd_full) begin
        r_shd_period <= cfg_period;
        r_shd_high   <= cfg_high;
        r_shd_offset <= cfg_offset;
        r_shd_full   <= 1'b1;
      end
    end
  end

  // Single phase timer shared by OFFSET, HIGH and LOW.
  clkgen_phase_cnt #(
    .CNT_W    (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .tc       (w_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and phase-timer load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_load = 1'b1;
          if (w_cfg_offset != '0) begin
            w_state_nxt = ST_OFFSET;
            w_load_val  = w_cfg_offset - c_one;
          end else begin
            w_state_nxt = w_start_state;
            w_load_val  = w_start_val;
          end
        end
      end
      ST_OFFSET: begin
        // Nothing has been driven high yet, so a stop aborts at once.
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tc) begin
          w_state_nxt = w_start_state;
          w_load      = 1'b1;
          w_load_val  = w_start_val;
        end
      end
      ST_HIGH: begin
        if (w_tc) begin
          if (!w_skip_low) begin
            w_state_nxt = ST_LOW;
            w_load      = 1'b1;
            w_load_val  = r_act_period - r_act_high - c_one;
          end else if (!enable) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = w_start_state;
            w_load      = 1'b1;
            w_load_val  = w_start_val;
          end
        end
      end
      ST_LOW: begin
        if (w_tc) begin
          if (!enable) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = w_start_state;
            w_load      = 1'b1;
            w_load_val  = w_start_val;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the outputs leave a flop.
  always_comb begin
    w_div_nxt  = (w_state_nxt == ST_HIGH);
    w_rise_nxt = (w_state_nxt == ST_HIGH) && (r_state != ST_HIGH);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= 1'b0;
      r_rise <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_rise <= w_rise_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign div_out    = r_div;
  assign rise_pulse = r_rise;
  assign busy       = r_busy;

`ifdef CLKGEN_CTRL_CNT_EN
  logic [31:0] r_pcnt;

  // Completed-period counter, restarted on each start from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if ((r_state == ST_IDLE) && (w_state_nxt != ST_IDLE)) begin
      r_pcnt <= '0;
    end else if (w_boundary && (r_pcnt != '1)) begin
      r_pcnt <= r_pcnt + 32'd1;
    end
  end

  assign period_cnt = r_pcnt;
`endif

endmodule
`default_nettype wire
